// File: rtl/rvc32_instr_packer.sv
// RV32I -> RVC instruction packer: compresses eligible instructions and packs
// halfwords into 32-bit words. Optional counters via RVC32_PACK_STATS_EN.
module rvc32_instr_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    input  logic        flush_req,
    output logic        flush_done
`ifdef RVC32_PACK_STATS_EN
    ,
    output logic [15:0] stat_total,
    output logic [15:0] stat_compressed
`endif
);

    typedef enum logic [0:0] {ST_EMPTY = 1'b0, ST_HALF = 1'b1} state_t;

    state_t      state_r;
    logic [15:0] pend_r;
    logic [31:0] out_word_r;
    logic        out_valid_r;
    logic        flush_done_r;
    logic        flush_seen_r;

    logic        accept_s;
    logic        flush_go_s;
    logic        comp_valid_s;
    logic [15:0] comp_half_s;

    logic [6:0]  opc_s;
    logic [2:0]  f3_s;
    logic [6:0]  f7_s;
    logic [4:0]  rd_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [11:0] imm_i_s;
    logic [11:0] imm_st_s;
    logic        is_addi_s, is_slli_s, is_add_s, is_lw_s, is_sw_s, is_jalr_s;
    logic        imm_fit6_s, lwsp_ok_s, swsp_ok_s, lw_ok_s, sw_ok_s;
    logic        rd_p_s, rs1_p_s, rs2_p_s;

    assign opc_s    = in_instr[6:0];
    assign f3_s     = in_instr[14:12];
    assign f7_s     = in_instr[31:25];
    assign rd_s     = in_instr[11:7];
    assign rs1_s    = in_instr[19:15];
    assign rs2_s    = in_instr[24:20];
    assign imm_i_s  = in_instr[31:20];
    assign imm_st_s = {in_instr[31:25], in_instr[11:7]};

    assign is_addi_s = (opc_s == 7'h13) && (f3_s == 3'd0);
    assign is_slli_s = (opc_s == 7'h13) && (f3_s == 3'd1) && (f7_s == 7'h00);
    assign is_add_s  = (opc_s == 7'h33) && (f3_s == 3'd0) && (f7_s == 7'h00);
    assign is_lw_s   = (opc_s == 7'h03) && (f3_s == 3'd2);
    assign is_sw_s   = (opc_s == 7'h23) && (f3_s == 3'd2);
    assign is_jalr_s = (opc_s == 7'h67) && (f3_s == 3'd0) && (imm_i_s == 12'h000);

    // Offset ranges: sign bits all equal for [-32,31]; zero high bits plus word alignment otherwise.
    assign imm_fit6_s = (imm_i_s[11:5] == 7'h00) || (imm_i_s[11:5] == 7'h7F);
    assign lwsp_ok_s  = (imm_i_s[11:8] == 4'h0) && (imm_i_s[1:0] == 2'b00);
    assign swsp_ok_s  = (imm_st_s[11:8] == 4'h0) && (imm_st_s[1:0] == 2'b00);
    assign lw_ok_s    = (imm_i_s[11:7] == 5'h00) && (imm_i_s[1:0] == 2'b00);
    assign sw_ok_s    = (imm_st_s[11:7] == 5'h00) && (imm_st_s[1:0] == 2'b00);
    assign rd_p_s     = (rd_s[4:3] == 2'b01);
    assign rs1_p_s    = (rs1_s[4:3] == 2'b01);
    assign rs2_p_s    = (rs2_s[4:3] == 2'b01);

    assign in_ready   = !out_valid_r || out_ready;
    assign accept_s   = in_valid && in_ready;
    assign flush_go_s = flush_req && !flush_seen_r && !accept_s;

    // First-match compression of the presented instruction.
    always_comb begin
        comp_valid_s = 1'b0;
        comp_half_s  = 16'h0000;
        if (in_instr == 32'h0000_0013) begin
            comp_valid_s = 1'b1;
            comp_half_s  = 16'h0001;
        end else if (is_addi_s && (rd_s != 5'd0) && (rs1_s == rd_s) && (imm_i_s != 12'h000) && imm_fit6_s) begin
            comp_valid_s = 1'b1;
            comp_half_s  = {3'b000, imm_i_s[5], rd_s, imm_i_s[4:0], 2'b01};
        end else if (is_addi_s && (rd_s != 5'd0) && (rs1_s == 5'd0) && imm_fit6_s) begin
            comp_valid_s = 1'b1;
            comp_half_s  = {3'b010, imm_i_s[5], rd_s, imm_i_s[4:0], 2'b01};
        end else if (is_slli_s && (rd_s != 5'd0) && (rs1_s == rd_s) && (rs2_s != 5'd0)) begin
            comp_valid_s = 1'b1;
            comp_half_s  = {3'b000, 1'b0, rd_s, rs2_s, 2'b10};
        end else if (is_add_s && (rd_s != 5'd0) && (rs1_s == 5'd0) && (rs2_s != 5'd0)) begin
            comp_valid_s = 1'b1;
            comp_half_s  = {4'b1000, rd_s, rs2_s, 2'b10};
        end else if (is_add_s && (rd_s != 5'd0) && (rs1_s == rd_s) && (rs2_s != 5'd0)) begin
            comp_valid_s = 1'b1;
            comp_half_s  = {4'b1001, rd_s, rs2_s, 2'b10};
        end else if (is_lw_s && (rs1_s == 5'd2) && (rd_s != 5'd0) && lwsp_ok_s) begin
            comp_valid_s = 1'b1;
            comp_half_s  = {3'b010, imm_i_s[5], rd_s, imm_i_s[4:2], imm_i_s[7:6], 2'b10};
        end else if (is_sw_s && (rs1_s == 5'd2) && swsp_ok_s) begin
            comp_valid_s = 1'b1;
            comp_half_s  = {3'b110, imm_st_s[5:2], imm_st_s[7:6], rs2_s, 2'b10};
        end else if (is_lw_s && rs1_p_s && rd_p_s && lw_ok_s) begin
            comp_valid_s = 1'b1;
            comp_half_s  = {3'b010, imm_i_s[5:3], rs1_s[2:0], imm_i_s[2], imm_i_s[6], rd_s[2:0], 2'b00};
        end else if (is_sw_s && rs1_p_s && rs2_p_s && sw_ok_s) begin
            comp_valid_s = 1'b1;
            comp_half_s  = {3'b110, imm_st_s[5:3], rs1_s[2:0], imm_st_s[2], imm_st_s[6], rs2_s[2:0], 2'b00};
        end else if (is_jalr_s && (rd_s == 5'd0) && (rs1_s != 5'd0)) begin
            comp_valid_s = 1'b1;
            comp_half_s  = {4'b1000, rs1_s, 5'd0, 2'b10};
        end else if (is_jalr_s && (rd_s == 5'd1) && (rs1_s != 5'd0)) begin
            comp_valid_s = 1'b1;
            comp_half_s  = {4'b1001, rs1_s, 5'd0, 2'b10};
        end else if (in_instr == 32'h0010_0073) begin
            comp_valid_s = 1'b1;
            comp_half_s  = 16'h9002;
        end else begin
            comp_valid_s = 1'b0;
            comp_half_s  = 16'h0000;
        end
    end

    // Packing FSM with one-entry output register and flush handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_EMPTY;
            pend_r       <= 16'h0000;
            out_word_r   <= 32'h0000_0000;
            out_valid_r  <= 1'b0;
            flush_done_r <= 1'b0;
            flush_seen_r <= 1'b0;
        end else begin
            flush_done_r <= 1'b0;
            if (out_ready) begin
                out_valid_r <= 1'b0;
            end
            if (!flush_req) begin
                flush_seen_r <= 1'b0;
            end
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        if (comp_valid_s) begin
                            pend_r  <= comp_half_s;
                            state_r <= ST_HALF;
                        end else begin
                            out_word_r  <= in_instr;
                            out_valid_r <= 1'b1;
                        end
                    end else if (flush_go_s) begin
                        flush_done_r <= 1'b1;
                        flush_seen_r <= 1'b1;
                    end
                end
                ST_HALF: begin
                    if (accept_s) begin
                        out_valid_r <= 1'b1;
                        if (comp_valid_s) begin
                            out_word_r <= {comp_half_s, pend_r};
                            pend_r     <= 16'h0000;
                            state_r    <= ST_EMPTY;
                        end else begin
                            out_word_r <= {in_instr[15:0], pend_r};
                            pend_r     <= in_instr[31:16];
                        end
                    end else if (flush_go_s && in_ready) begin
                        // Pad the odd halfword with c.nop so the word stays decodable.
                        out_word_r   <= {16'h0001, pend_r};
                        out_valid_r  <= 1'b1;
                        pend_r       <= 16'h0000;
                        state_r      <= ST_EMPTY;
                        flush_done_r <= 1'b1;
                        flush_seen_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                    pend_r  <= 16'h0000;
                end
            endcase
        end
    end

    assign out_valid  = out_valid_r;
    assign out_word   = out_word_r;
    assign flush_done = flush_done_r;

`ifdef RVC32_PACK_STATS_EN
    logic [15:0] stat_total_r;
    logic [15:0] stat_compressed_r;

    // Saturating acceptance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_total_r      <= 16'h0000;
            stat_compressed_r <= 16'h0000;
        end else if (accept_s) begin
            if (stat_total_r != 16'hFFFF) begin
                stat_total_r <= stat_total_r + 16'd1;
            end
            if (comp_valid_s && (stat_compressed_r != 16'hFFFF)) begin
                stat_compressed_r <= stat_compressed_r + 16'd1;
            end
        end
    end

    assign stat_total      = stat_total_r;
    assign stat_compressed = stat_compressed_r;
`endif

endmodule

// File: tb/tb_rvc32_instr_packer.sv
// Self-checking bench for rvc32_instr_packer: directed scenarios plus random
// traffic against a halfword-stream reference model.
module tb_rvc32_instr_packer;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, flush_req;
    logic [31:0] in_instr;
    logic        in_ready, out_valid, flush_done;
    logic [31:0] out_word;
`ifdef RVC32_PACK_STATS_EN
    logic [15:0] stat_total, stat_compressed;
`endif

    always #5 clk = ~clk;

    rvc32_instr_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .flush_req  (flush_req),
        .flush_done (flush_done)
`ifdef RVC32_PACK_STATS_EN
        ,
        .stat_total      (stat_total),
        .stat_compressed (stat_compressed)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference model: stream of halfwords awaiting pairing, plus the output slot.
    logic [15:0] m_hq[$];
    logic        m_slot_v, m_done, m_seen;
    logic [31:0] m_slot_w;
    int          m_total, m_comp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] mk(input int h);
        logic [31:0] t;
        t = h;
        return {1'b1, t[15:0]};
    endfunction

    function automatic logic [16:0] ref_compress(input logic [31:0] i);
        int opc, f3, f7, rd, rs1, rs2, imm, simm;
        opc  = int'(i[6:0]);
        f3   = int'(i[14:12]);
        f7   = int'(i[31:25]);
        rd   = int'(i[11:7]);
        rs1  = int'(i[19:15]);
        rs2  = int'(i[24:20]);
        imm  = int'($signed(i[31:20]));
        simm = int'($signed({i[31:25], i[11:7]}));
        if (i == 32'h0000_0013) return mk(1);
        if (opc == 19 && f3 == 0 && rd != 0 && rs1 == rd && imm != 0 && imm >= -32 && imm <= 31)
            return mk((((imm >> 5) & 1) << 12) | (rd << 7) | ((imm & 31) << 2) | 1);
        if (opc == 19 && f3 == 0 && rd != 0 && rs1 == 0 && imm >= -32 && imm <= 31)
            return mk((2 << 13) | (((imm >> 5) & 1) << 12) | (rd << 7) | ((imm & 31) << 2) | 1);
        if (opc == 19 && f3 == 1 && f7 == 0 && rd != 0 && rs1 == rd && rs2 != 0)
            return mk((rd << 7) | (rs2 << 2) | 2);
        if (opc == 51 && f3 == 0 && f7 == 0 && rd != 0 && rs1 == 0 && rs2 != 0)
            return mk((8 << 12) | (rd << 7) | (rs2 << 2) | 2);
        if (opc == 51 && f3 == 0 && f7 == 0 && rd != 0 && rs1 == rd && rs2 != 0)
            return mk((9 << 12) | (rd << 7) | (rs2 << 2) | 2);
        if (opc == 3 && f3 == 2 && rs1 == 2 && rd != 0 && imm >= 0 && imm <= 252 && (imm % 4) == 0)
            return mk((2 << 13) | (((imm >> 5) & 1) << 12) | (rd << 7) | (((imm >> 2) & 7) << 4) | (((imm >> 6) & 3) << 2) | 2);
        if (opc == 35 && f3 == 2 && rs1 == 2 && simm >= 0 && simm <= 252 && (simm % 4) == 0)
            return mk((6 << 13) | (((simm >> 2) & 15) << 9) | (((simm >> 6) & 3) << 7) | (rs2 << 2) | 2);
        if (opc == 3 && f3 == 2 && rs1 >= 8 && rs1 <= 15 && rd >= 8 && rd <= 15 && imm >= 0 && imm <= 124 && (imm % 4) == 0)
            return mk((2 << 13) | (((imm >> 3) & 7) << 10) | ((rs1 - 8) << 7) | (((imm >> 2) & 1) << 6) | (((imm >> 6) & 1) << 5) | ((rd - 8) << 2));
        if (opc == 35 && f3 == 2 && rs1 >= 8 && rs1 <= 15 && rs2 >= 8 && rs2 <= 15 && simm >= 0 && simm <= 124 && (simm % 4) == 0)
            return mk((6 << 13) | (((simm >> 3) & 7) << 10) | ((rs1 - 8) << 7) | (((simm >> 2) & 1) << 6) | (((simm >> 6) & 1) << 5) | ((rs2 - 8) << 2));
        if (opc == 103 && f3 == 0 && imm == 0 && rd == 0 && rs1 != 0)
            return mk((8 << 12) | (rs1 << 7) | 2);
        if (opc == 103 && f3 == 0 && imm == 0 && rd == 1 && rs1 != 0)
            return mk((9 << 12) | (rs1 << 7) | 2);
        if (i == 32'h0010_0073) return mk(32'h9002);
        return {1'b0, 16'h0000};
    endfunction

    function automatic logic [31:0] rand_instr();
        int          pool[9] = '{0, 1, 2, 5, 8, 9, 12, 15, 31};
        logic [31:0] rd, rs1, rs2, imm, r;
        int          k;
        rd  = pool[$urandom_range(0, 8)];
        rs2 = pool[$urandom_range(0, 8)];
        k   = $urandom_range(0, 3);
        rs1 = (k < 2) ? rd : ((k == 2) ? 32'd0 : pool[$urandom_range(0, 8)]);
        r   = $urandom;
        case ($urandom_range(0, 11))
            0: begin
                imm = $urandom_range(0, 80) - 40;
                return {imm[11:0], rs1[4:0], 3'b000, rd[4:0], 7'h13};
            end
            1: return {7'h00, r[4:0], rs1[4:0], 3'b001, rd[4:0], 7'h13};
            2: return {(r[0] ? 7'h20 : 7'h00), rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'h33};
            3: begin
                rs1 = r[1] ? 32'd2 : pool[$urandom_range(0, 8)];
                imm = r[2] ? ($urandom_range(0, 67) * 4 - 8) : $urandom_range(0, 255);
                return {imm[11:0], rs1[4:0], 3'b010, rd[4:0], 7'h03};
            end
            4: begin
                rs1 = r[1] ? 32'd2 : pool[$urandom_range(0, 8)];
                imm = r[2] ? ($urandom_range(0, 67) * 4 - 8) : $urandom_range(0, 255);
                return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
            end
            5: begin
                imm = r[3] ? 32'd4 : 32'd0;
                rd  = r[5:4] == 2'd0 ? 32'd5 : {31'd0, r[6]};
                return {imm[11:0], rs2[4:0], 3'b000, rd[4:0], 7'h67};
            end
            6: return 32'h0010_0073;
            7: return 32'h0000_0013;
            8: return {r[31:12], rd[4:0], 7'h37};
            9: return {r[31:12], rd[4:0], 7'h6F};
            10: return {r[31:25], rs2[4:0], rs1[4:0], 3'b000, r[11:7], 7'h63};
            default: return {r[31:12], rd[4:0], 7'h17};
        endcase
    endfunction

    task automatic model_reset();
        m_hq.delete();
        m_slot_v = 1'b0;
        m_slot_w = 32'h0;
        m_done   = 1'b0;
        m_seen   = 1'b0;
        m_total  = 0;
        m_comp   = 0;
    endtask

    task automatic model_step();
        logic        rdy, acc;
        logic [16:0] c;
        rdy    = !m_slot_v || out_ready;
        acc    = in_valid && rdy;
        m_done = 1'b0;
        if (m_slot_v && out_ready) m_slot_v = 1'b0;
        if (acc) begin
            c = ref_compress(in_instr);
            if (m_total < 65535) m_total++;
            if (c[16] && m_comp < 65535) m_comp++;
            if (c[16]) m_hq.push_back(c[15:0]);
            else begin
                m_hq.push_back(in_instr[15:0]);
                m_hq.push_back(in_instr[31:16]);
            end
            if (m_hq.size() >= 2) begin
                m_slot_w = {m_hq[1], m_hq[0]};
                void'(m_hq.pop_front());
                void'(m_hq.pop_front());
                m_slot_v = 1'b1;
            end
        end else if (flush_req && !m_seen) begin
            if (m_hq.size() == 0) begin
                m_done = 1'b1;
                m_seen = 1'b1;
            end else if (rdy) begin
                m_slot_w = {16'h0001, m_hq[0]};
                void'(m_hq.pop_front());
                m_slot_v = 1'b1;
                m_done   = 1'b1;
                m_seen   = 1'b1;
            end
        end
        if (!flush_req) m_seen = 1'b0;
    endtask

    task automatic check_outputs();
        chk("in_ready", 32'(in_ready), 32'(!m_slot_v || out_ready));
        chk("out_valid", 32'(out_valid), 32'(m_slot_v));
        if (m_slot_v) chk("out_word", out_word, m_slot_w);
        chk("flush_done", 32'(flush_done), 32'(m_done));
`ifdef RVC32_PACK_STATS_EN
        chk("stat_total", 32'(stat_total), m_total);
        chk("stat_compressed", 32'(stat_compressed), m_comp);
`endif
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = ins;
        out_ready = ordy;
        flush_req = fl;
        tick();
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        out_ready = 1'b1;
        flush_req = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_word", out_word, 32'h0);
        chk("rst_flush_done", 32'(flush_done), 32'h0);
`ifdef RVC32_PACK_STATS_EN
        chk("rst_stat_total", 32'(stat_total), 32'h0);
        chk("rst_stat_comp", 32'(stat_compressed), 32'h0);
`endif
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h1);
    endtask

    initial begin
        apply_reset();

        // addi x5,x5,3 then nop pack into one word
        drive(1'b1, 32'h0032_8293, 1'b1, 1'b0);
        chk("r026_no_word", 32'(out_valid), 32'h0);
        drive(1'b1, 32'h0000_0013, 1'b1, 1'b0);
        chk("r026_word", out_word, 32'h0001_028D);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // nop, lui, then flush held for two cycles gives a single pulse
        drive(1'b1, 32'h0000_0013, 1'b1, 1'b0);
        drive(1'b1, 32'h1234_50B7, 1'b1, 1'b0);
        chk("r027_word", out_word, 32'h50B7_0001);
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        chk("r027_flush_word", out_word, 32'h0001_1234);
        chk("r027_flush_done", 32'(flush_done), 32'h1);
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        chk("r027_single_pulse", 32'(flush_done), 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // ebreak then flush
        drive(1'b1, 32'h0010_0073, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        chk("r028_word", out_word, 32'h0001_9002);
        chk("r028_done", 32'(flush_done), 32'h1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // flush in EMPTY pulses one cycle later
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        chk("empty_flush_done", 32'(flush_done), 32'h1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // input beats flush in the same cycle; flush follows later
        drive(1'b1, 32'h0000_0013, 1'b1, 1'b0);
        drive(1'b1, 32'h0010_0073, 1'b1, 1'b1);
        chk("prio_word", out_word, 32'h9002_0001);
        chk("prio_no_done", 32'(flush_done), 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        chk("prio_late_done", 32'(flush_done), 32'h1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // backpressure: word held stable for five cycles
        drive(1'b1, 32'h1234_50B7, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h0000_006F, 1'b0, 1'b0);
            chk("r029_stall_ready", 32'(in_ready), 32'h0);
            chk("r029_stable", out_word, 32'h1234_50B7);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("r029_drained", 32'(out_valid), 32'h0);
        chk("r029_ready", 32'(in_ready), 32'h1);

        // reset mid-operation discards pending state
        drive(1'b1, 32'h0000_0013, 1'b1, 1'b0);
        drive(1'b1, 32'h1234_50B7, 1'b0, 1'b0);
        chk("r030_pending", 32'(out_valid), 32'h1);
        apply_reset();
        drive(1'b1, 32'h0000_0013, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        chk("r030_word", out_word, 32'h0001_0001);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("r030_only_one", 32'(out_valid), 32'h0);

`ifdef RVC32_PACK_STATS_EN
        apply_reset();
        drive(1'b1, 32'h0000_0013, 1'b1, 1'b0);
        drive(1'b1, 32'h0010_0073, 1'b1, 1'b0);
        drive(1'b1, 32'h0032_8293, 1'b1, 1'b0);
        drive(1'b1, 32'h1234_50B7, 1'b1, 1'b0);
        drive(1'b1, 32'h0000_006F, 1'b1, 1'b0);
        chk("r031_total", 32'(stat_total), 32'd5);
        chk("r031_comp", 32'(stat_compressed), 32'd3);
`endif

        // random traffic against the model
        flush_req = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_instr  = rand_instr();
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) flush_req = !flush_req;
            tick();
        end
        flush_req = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
